write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/lc3b_types.sv | 16 +
 rtl/wb_entry.sv | 55 +++++
 rtl/write_buffer.sv | 167 ++++++++++++++++
 tb/tb_write_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the write-buffer tag and state types.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cache_line;
   typedef logic [11:0]  lc3b_line_tag;

   typedef enum logic [2:0] {
      IDLE,
      WR_RESP,
      RD_MEM,
      RD_RESP,
      DRAIN
   } lc3b_wb_state;

endpackage

// File: rtl/wb_entry.sv
// Single buffered line: valid bit, line tag and line data, with tag compare.
module wb_entry
   import lc3b_types::*;
#(
   parameter int TAG_W = $bits(lc3b_line_tag)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  lc3b_cache_line   data_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             valid,
   output logic [TAG_W-1:0] tag,
   output lc3b_cache_line   data,
   output logic             hit
);

   logic             valid_q, valid_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   lc3b_cache_line   data_q, data_d;

   // A load on the same cycle as a clear wins: the drain finished and a new line is captured.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         tag_d   = tag_in;
         data_d  = data_in;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign valid = valid_q;
   assign tag   = tag_q;
   assign data  = data_q;
   assign hit   = valid_q && (tag_q == tag_in);

endmodule

// File: rtl/write_buffer.sv
// One-line write buffer between the L1 arbiter and physical memory.
// Define WB_READ_FORWARD_EN to serve reads that hit the buffered line directly.
module write_buffer
   import lc3b_types::*;
#(
   parameter int LINE_OFFSET_BITS = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           read,
   input  logic           write,
   input  lc3b_word       address,
   input  lc3b_cache_line wdata,
   output logic           resp,
   output lc3b_cache_line rdata,
   output logic           pmem_read,
   output logic           pmem_write,
   output lc3b_word       pmem_address,
   output lc3b_cache_line pmem_wdata,
   input  logic           pmem_resp,
   input  lc3b_cache_line pmem_rdata
);

   localparam int       TAG_W       = 16 - LINE_OFFSET_BITS;
   localparam lc3b_word OFFSET_MASK = lc3b_word'((1 << LINE_OFFSET_BITS) - 1);

   lc3b_wb_state   state_q, state_d;
   logic           resp_q, resp_d;
   lc3b_cache_line rdata_q, rdata_d;
   logic           pmem_read_q, pmem_read_d;
   logic           pmem_write_q, pmem_write_d;
   lc3b_word       pmem_address_q, pmem_address_d;
   lc3b_cache_line pmem_wdata_q, pmem_wdata_d;

   logic             ent_load, ent_clear, ent_valid, ent_hit;
   logic [TAG_W-1:0] addr_tag, ent_tag;
   lc3b_cache_line   ent_data;
   lc3b_word         line_addr;
   logic             go_drain, go_read;

   assign line_addr = address & ~OFFSET_MASK;
   assign addr_tag  = address[15:LINE_OFFSET_BITS];

   wb_entry #(.TAG_W(TAG_W)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load    (ent_load),
      .clear   (ent_clear),
      .data_in (wdata),
      .tag_in  (addr_tag),
      .valid   (ent_valid),
      .tag     (ent_tag),
      .data    (ent_data),
      .hit     (ent_hit)
   );

   always_comb begin
      state_d        = state_q;
      resp_d         = 1'b0;
      rdata_d        = rdata_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      ent_load       = 1'b0;
      ent_clear      = 1'b0;
      go_drain       = 1'b0;
      go_read        = 1'b0;

      case (state_q)
         IDLE: begin
            // write outranks read when both are raised
            if (write) begin
               if (!ent_valid || ent_hit) begin
                  ent_load = 1'b1;
                  resp_d   = 1'b1;
                  state_d  = WR_RESP;
               end else begin
                  go_drain = 1'b1;
               end
            end else if (read) begin
`ifdef WB_READ_FORWARD_EN
               if (ent_hit) begin
                  rdata_d = ent_data;
                  resp_d  = 1'b1;
                  state_d = RD_RESP;
               end else begin
                  go_read = 1'b1;
               end
`else
               if (ent_hit) begin
                  go_drain = 1'b1;
               end else begin
                  go_read = 1'b1;
               end
`endif
            end else if (ent_valid) begin
               go_drain = 1'b1;
            end
         end
         WR_RESP, RD_RESP: state_d = IDLE;
         RD_MEM: begin
            if (pmem_resp) begin
               pmem_read_d = 1'b0;
               rdata_d     = pmem_rdata;
               resp_d      = 1'b1;
               state_d     = RD_RESP;
            end
         end
         DRAIN: begin
            // a write that waited on this drain is captured as the slot frees up
            if (pmem_resp) begin
               pmem_write_d = 1'b0;
               ent_clear    = 1'b1;
               if (write) begin
                  ent_load = 1'b1;
                  resp_d   = 1'b1;
                  state_d  = WR_RESP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (go_drain) begin
         state_d        = DRAIN;
         pmem_write_d   = 1'b1;
         pmem_address_d = {ent_tag, {LINE_OFFSET_BITS{1'b0}}};
         pmem_wdata_d   = ent_data;
      end
      if (go_read) begin
         state_d        = RD_MEM;
         pmem_read_d    = 1'b1;
         pmem_address_d = line_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         resp_q         <= 1'b0;
         rdata_q        <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         resp_q         <= resp_d;
         rdata_q        <= rdata_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
      end
   end

   assign resp         = resp_q;
   assign rdata        = rdata_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_write_buffer.sv
// Testbench for write_buffer: directed vector table, reset corner cases and
// randomized traffic checked against a line-coherent memory model.
module tb_write_buffer;

   logic         clk, rst, read, write;
   logic [15:0]  address;
   logic [127:0] wdata;
   logic         resp;
   logic [127:0] rdata;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;

   write_buffer #(.LINE_OFFSET_BITS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .read         (read),
      .write        (write),
      .address      (address),
      .wdata        (wdata),
      .resp         (resp),
      .rdata        (rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] D0 = {4{32'hD0D0_0000}};
   localparam logic [127:0] D1 = {4{32'hD1D1_1111}};
   localparam logic [127:0] D2 = {4{32'hD2D2_2222}};
   localparam int OP_W = 0, OP_R = 1, OP_F = 2;
   localparam int TLAT = 3;
`ifdef WB_READ_FORWARD_EN
   localparam int HIT_LAT = 1, HIT_W = 0, HIT_R = 0, FL_W = 1;
`else
   localparam int HIT_LAT = 2 * TLAT + 2, HIT_W = 1, HIT_R = 1, FL_W = 0;
`endif

   // Reference: a flat line-addressed memory. Reads must return the latest
   // line written by upstream; physical memory must match after a flush.
   logic [127:0] phys   [int];
   logic [127:0] shadow [int];
   int mem_lat = TLAT;
   int mem_cnt = 0;
   int wr_count = 0, rd_count = 0, rd8000_cycles = 0;

   function automatic logic [127:0] mem_init(input logic [11:0] t);
      return {8{4'hA, t}};
   endfunction

   function automatic logic [127:0] expect_line(input logic [11:0] t);
      if (shadow.exists(int'(t))) return shadow[int'(t)];
      return mem_init(t);
   endfunction

   task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Physical memory: responds with a one-cycle pmem_resp after mem_lat request cycles.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
   end
   always @(negedge clk) begin
      if (rst) begin
         mem_cnt   = 0;
         pmem_resp = 1'b0;
      end else if (pmem_resp) begin
         pmem_resp = 1'b0;
         mem_cnt   = 0;
      end else if (pmem_read || pmem_write) begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            pmem_resp = 1'b1;
            if (pmem_write) begin
               phys[int'(pmem_address[15:4])] = pmem_wdata;
               wr_count++;
            end else begin
               pmem_rdata = phys.exists(int'(pmem_address[15:4])) ?
                            phys[int'(pmem_address[15:4])] : mem_init(pmem_address[15:4]);
               rd_count++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((pmem_read && pmem_write) || ((pmem_read || pmem_write) && pmem_address[3:0] != 4'h0)) begin
            errors++;
            $display("FAIL pmem_protocol: read=%0b write=%0b addr=%0h required exclusive, line-aligned",
                     pmem_read, pmem_write, pmem_address);
         end
         if (pmem_read && pmem_address == 16'h8000) rd8000_cycles++;
      end
   end

   task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] d, output int lat, output logic [127:0] rd_out);
      bit got;
      got = 0;
      lat = 0;
      read = rd; write = wr; address = a; wdata = d;
      while (!got && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (resp) got = 1;
      end
      rd_out = rdata;
      if (!got) chk_eq("resp_timeout", 0, 1);
      if (wr && got) shadow[int'(a[15:4])] = d;
      read = 1'b0; write = 1'b0;
      @(posedge clk); #1;
      chk_eq("resp_one_cycle", resp, 1'b0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int           op;
      logic [15:0]  addr;
      logic [127:0] data;
      int           exp_lat;
      int           exp_w;
      int           exp_r;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t tbl [8];
   logic [11:0] tags [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required $finish");
      $fatal(1);
   end

   initial begin
      int lat, w0, r0, c0;
      logic [127:0] rv;
      bit seen;

      tbl[0] = '{OP_W, 16'h1230, D0, 1, 0, 0, '0};
      tbl[1] = '{OP_W, 16'h1238, D1, 1, 0, 0, '0};
      tbl[2] = '{OP_W, 16'h4560, D2, TLAT + 1, 1, 0, '0};
      tbl[3] = '{OP_R, 16'h4564, '0, HIT_LAT, HIT_W, HIT_R, D2};
      tbl[4] = '{OP_R, 16'h8000, '0, TLAT + 1, 0, 1, {8{16'hA800}}};
      tbl[5] = '{OP_F, 16'h0000, '0, 0, FL_W, 0, '0};
      tbl[6] = '{OP_R, 16'h1230, '0, TLAT + 1, 0, 1, D1};
      tbl[7] = '{OP_R, 16'h4560, '0, TLAT + 1, 0, 1, D2};
      tags = '{12'h123, 12'h456, 12'h800, 12'hABC};

      rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
      #1 rst = 1'b1;
      #2;
      chk_eq("reset_outputs", {resp, pmem_read, pmem_write, pmem_address, rdata, pmem_wdata}, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         w0 = wr_count; r0 = rd_count;
         if (tbl[i].op == OP_F) begin
            idle_cycles(3 * TLAT + 10);
            chk_eq($sformatf("vec%0d_flush_writes", i), wr_count - w0, tbl[i].exp_w);
         end else begin
            issue(tbl[i].op == OP_R, tbl[i].op == OP_W, tbl[i].addr, tbl[i].data, lat, rv);
            chk_eq($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk_eq($sformatf("vec%0d_pmem_writes", i), wr_count - w0, tbl[i].exp_w);
            chk_eq($sformatf("vec%0d_pmem_reads", i), rd_count - r0, tbl[i].exp_r);
            if (tbl[i].op == OP_R) chk_eq($sformatf("vec%0d_rdata", i), rv, tbl[i].exp_rdata);
         end
      end

      // read miss with a five-cycle memory
      mem_lat = 5;
      c0 = rd8000_cycles;
      issue(1'b1, 1'b0, 16'h8004, '0, lat, rv);
      chk_eq("miss5_latency", lat, 6);
      chk_eq("miss5_pmem_read_cycles", rd8000_cycles - c0, 5);
      chk_eq("miss5_rdata", rv, mem_init(12'h800));

      for (int n = 0; n < 150; n++) begin
         int kind;
         logic [15:0] a;
         logic [127:0] d;
         idle_cycles($urandom_range(0, 2));
         mem_lat = $urandom_range(1, 4);
         kind = $urandom_range(0, 9);
         a = {tags[$urandom_range(0, 3)], 4'($urandom)};
         d = {$urandom, $urandom, $urandom, $urandom};
         if (kind < 4) begin
            issue(1'b1, 1'b0, a, d, lat, rv);
            chk_eq($sformatf("rand%0d_rdata_%0h", n, a), rv, expect_line(a[15:4]));
         end else begin
            issue(kind == 9, 1'b1, a, d, lat, rv);
         end
      end

      idle_cycles(40);
      foreach (shadow[k]) begin
         chk_eq($sformatf("flushed_line_%0h", k), phys.exists(k) ? phys[k] : 'x, shadow[k]);
      end

      // reset while a drain is in flight
      mem_lat = 4;
      issue(1'b0, 1'b1, 16'h1230, D0, lat, rv);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (pmem_write) seen = 1;
      end
      chk_eq("drain_started", seen, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_eq("rst_mid_drain_outputs", {resp, pmem_read, pmem_write, pmem_address, rdata, pmem_wdata}, '0);
      @(posedge clk); #1 rst = 1'b0;
      w0 = wr_count;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pmem_write) seen = 1;
      end
      chk_eq("no_write_after_rst", seen, 1'b0);
      chk_eq("no_mem_write_after_rst", wr_count - w0, 0);

      // reset while a memory read is in flight
      @(posedge clk); #1;
      read = 1'b1; address = 16'h9000;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (pmem_read) seen = 1;
      end
      chk_eq("read_started", seen, 1'b1);
      rst = 1'b1;
      #1;
      chk_eq("rst_mid_read_outputs", {resp, pmem_read}, 2'b00);
      read = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp || pmem_read) seen = 1;
      end
      chk_eq("no_resp_after_rst", seen, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
